wb128_to_32_bridge: RTL and testbench



---
 rtl/wb128_to_32_bridge_pkg.sv | 25 ++
 rtl/wb128_to_32_bridge_if.sv | 26 ++
 rtl/wb128_to_32_bridge.sv | 177 +++++++++++++++++
 tb/tb_wb128_to_32_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb128_to_32_bridge_pkg.sv
// Shared types for the 128-to-32 Wishbone downsizer.
// Lane helpers work on the 4-bit per-word activity mask.
package wb128_to_32_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP,
    RESP
  } state_t;

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    if (m[0]) return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else return 2'd3;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [15:0] sel);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = |sel[4*k +: 4];
    return r;
  endfunction

endpackage

// File: rtl/wb128_to_32_bridge_if.sv
// Wishbone bus bundle, parameterised on data width.
// master drives request fields, slave drives the response.
interface wb128_to_32_bridge_if #(
  parameter int DW = 32,
  parameter int SW = DW / 8
);
  logic [31:0]   adr;
  logic [SW-1:0] sel;
  logic          we;
  logic [DW-1:0] wdat;
  logic          cyc;
  logic          stb;
  logic [DW-1:0] rdat;
  logic          ack;
  logic          err;

  modport master (
    output adr, sel, we, wdat, cyc, stb,
    input  rdat, ack, err
  );

  modport slave (
    input  adr, sel, we, wdat, cyc, stb,
    output rdat, ack, err
  );
endinterface

// File: rtl/wb128_to_32_bridge.sv
// Splits each 128-bit Wishbone access into per-lane 32-bit accesses,
// lowest active lane first, and reassembles read data.
module wb128_to_32_bridge
  import wb128_to_32_bridge_pkg::*;
#(
  parameter int WB_DWIDTH = 128,
  parameter int WB_SWIDTH = 16,
  parameter int TIMEOUT   = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  wb128_to_32_bridge_if.slave  s,
  wb128_to_32_bridge_if.master m
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t               state_q, state_d;
  logic [31:0]          adr_q, adr_d;
  logic                 we_q, we_d;
  logic [WB_SWIDTH-1:0] sel_q, sel_d;
  logic [WB_DWIDTH-1:0] wdat_q, wdat_d;
  logic [3:0]           mask_q, mask_d;
  logic [1:0]           lane_q, lane_d;
  logic [WB_DWIDTH-1:0] rbuf_q, rbuf_d;
  logic [WB_DWIDTH-1:0] rdat_q, rdat_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [31:0]          madr_q, madr_d;
  logic [3:0]           msel_q, msel_d;
  logic [31:0]          mwdat_q, mwdat_d;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    mask_d  = mask_q;
    lane_d  = lane_q;
    rbuf_d  = rbuf_q;
    rdat_d  = '0;
    cnt_d   = cnt_q;
    cyc_d   = 1'b0;
    stb_d   = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s.cyc && s.stb) begin
          adr_d  = s.adr & 32'hFFFF_FFF0;
          we_d   = s.we;
          sel_d  = s.sel;
          wdat_d = s.wdat;
          rbuf_d = '0;
          cnt_d  = '0;
          mask_d = lane_mask(s.sel);
          if (mask_d == 4'd0) begin
            state_d = RESP;
            ack_d   = 1'b1;
          end else begin
            lane_d  = low_lane(mask_d);
            state_d = XFER;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
          end
        end
      end
      XFER: begin
        if (!s.cyc) begin
          state_d = IDLE;
          mask_d  = '0;
        end else if (m.err) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdat_d  = rbuf_q;
          mask_d  = '0;
        end else if (m.ack) begin
          if (!we_q) rbuf_d[{lane_q, 5'b0} +: 32] = m.rdat;
          mask_d = mask_q & ~(4'b0001 << lane_q);
          cnt_d  = '0;
          if (mask_d != 4'd0) begin
            state_d = GAP;
            lane_d  = low_lane(mask_d);
            cyc_d   = 1'b1;
          end else begin
            state_d = RESP;
            ack_d   = 1'b1;
            rdat_d  = rbuf_d;
          end
        end else if (TIMEOUT != 0 && cnt_q == TLAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdat_d  = rbuf_q;
          mask_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end
      end
      GAP: begin
        if (!s.cyc) begin
          state_d = IDLE;
          mask_d  = '0;
        end else begin
          state_d = XFER;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Lane fields follow the lane that will be on the bus next cycle.
    madr_d  = adr_d | {28'd0, lane_d, 2'b00};
    msel_d  = sel_d[{lane_d, 2'b00} +: 4];
    mwdat_d = wdat_d[{lane_d, 5'b0} +: 32];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      mask_q  <= '0;
      lane_q  <= '0;
      rbuf_q  <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      madr_q  <= '0;
      msel_q  <= '0;
      mwdat_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      mask_q  <= mask_d;
      lane_q  <= lane_d;
      rbuf_q  <= rbuf_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      madr_q  <= madr_d;
      msel_q  <= msel_d;
      mwdat_q <= mwdat_d;
    end
  end

  assign s.rdat = rdat_q;
  assign s.ack  = ack_q;
  assign s.err  = err_q;
  assign m.adr  = madr_q;
  assign m.sel  = msel_q;
  assign m.we   = we_q;
  assign m.wdat = mwdat_q;
  assign m.cyc  = cyc_q;
  assign m.stb  = stb_q;

endmodule

// File: tb/tb_wb128_to_32_bridge.sv
// Directed bench for the 128-to-32 Wishbone downsizer.
// Downstream slave acks in its first strobe cycle unless stalled.
module tb_wb128_to_32_bridge;

  logic clk = 1'b0;
  logic rst;
  logic hang;
  logic err_en;
  int   tests = 0;
  int   fails = 0;

  wb128_to_32_bridge_if #(.DW(128), .SW(16)) s_bus ();
  wb128_to_32_bridge_if #(.DW(32),  .SW(4))  m_bus ();

  wb128_to_32_bridge #(
    .WB_DWIDTH(128),
    .WB_SWIDTH(16),
    .TIMEOUT(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .s(s_bus),
    .m(m_bus)
  );

  always #5 clk = ~clk;

  logic [3:0] nib;
  always_comb begin
    nib = 4'({1'b0, m_bus.adr[3:2]} + 3'd1);
    m_bus.rdat = {8{nib}};
    m_bus.ack  = 1'b0;
    m_bus.err  = 1'b0;
    if (m_bus.cyc && m_bus.stb && !hang) begin
      if (err_en && m_bus.adr[3:2] == 2'd1) m_bus.err = 1'b1;
      else m_bus.ack = 1'b1;
    end
  end

  logic [31:0] log_adr[$];
  logic [31:0] log_wdat[$];
  logic [3:0]  log_sel[$];
  logic        log_we[$];
  int stb_cnt, cyc_cnt, gap_cnt, ack_cnt, err_cnt;

  always @(posedge clk) begin
    if (m_bus.cyc) cyc_cnt++;
    if (m_bus.stb) stb_cnt++;
    if (m_bus.cyc && !m_bus.stb) gap_cnt++;
    if (s_bus.ack) ack_cnt++;
    if (s_bus.err) err_cnt++;
    if (m_bus.cyc && m_bus.stb && (m_bus.ack || m_bus.err)) begin
      log_adr.push_back(m_bus.adr);
      log_wdat.push_back(m_bus.wdat);
      log_sel.push_back(m_bus.sel);
      log_we.push_back(m_bus.we);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    log_adr.delete();
    log_wdat.delete();
    log_sel.delete();
    log_we.delete();
    stb_cnt = 0;
    cyc_cnt = 0;
    gap_cnt = 0;
    ack_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic req(input logic [31:0] a, input logic [15:0] sl,
                     input logic w, input logic [127:0] wd,
                     output int lat, output logic ak, output logic er,
                     output logic [127:0] rd);
    s_bus.adr  = a;
    s_bus.sel  = sl;
    s_bus.we   = w;
    s_bus.wdat = wd;
    s_bus.cyc  = 1'b1;
    s_bus.stb  = 1'b1;
    lat = 0;
    ak  = 1'b0;
    er  = 1'b0;
    rd  = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (s_bus.ack || s_bus.err) begin
        lat = i;
        ak  = s_bus.ack;
        er  = s_bus.err;
        rd  = s_bus.rdat;
        break;
      end
    end
    s_bus.cyc = 1'b0;
    s_bus.stb = 1'b0;
  endtask

  int           lat;
  logic         ak, er;
  logic [127:0] rd;

  initial begin
    rst        = 1'b1;
    hang       = 1'b0;
    err_en     = 1'b0;
    s_bus.adr  = '0;
    s_bus.sel  = '0;
    s_bus.we   = 1'b0;
    s_bus.wdat = '0;
    s_bus.cyc  = 1'b0;
    s_bus.stb  = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {m_bus.cyc, m_bus.stb, s_bus.ack, s_bus.err, m_bus.we}, 0);
    chk("rst_rdat", s_bus.rdat, 0);
    chk("rst_madr", {m_bus.adr, m_bus.sel, m_bus.wdat}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // full read, zero wait
    clr();
    req(32'h1000_0020, 16'hFFFF, 1'b0, '0, lat, ak, er, rd);
    chk("full_lat", lat, 8);
    chk("full_ack", {ak, er}, 2'b10);
    chk("full_rdat", rd, 128'h44444444_33333333_22222222_11111111);
    chk("full_n", log_adr.size(), 4);
    chk("full_a0", log_adr[0], 32'h1000_0020);
    chk("full_a1", log_adr[1], 32'h1000_0024);
    chk("full_a2", log_adr[2], 32'h1000_0028);
    chk("full_a3", log_adr[3], 32'h1000_002C);
    chk("full_gaps", gap_cnt, 3);
    chk("full_stb", stb_cnt, 4);
    repeat (2) @(posedge clk);
    #1;
    chk("full_ack_pulse", ack_cnt, 1);

    // sparse write, lanes 0 and 3
    clr();
    req(32'h2000_0040, 16'hF00F, 1'b1,
        {32'hAAAA0000, 32'h12345678, 32'h9ABCDEF0, 32'h0000BBBB},
        lat, ak, er, rd);
    chk("sw_lat", lat, 4);
    chk("sw_ack", {ak, er}, 2'b10);
    chk("sw_rdat", rd, 0);
    chk("sw_n", log_adr.size(), 2);
    chk("sw_0", {log_adr[0], log_wdat[0], log_sel[0], 3'b0, log_we[0]},
        {32'h2000_0040, 32'h0000BBBB, 4'hF, 4'h1});
    chk("sw_1", {log_adr[1], log_wdat[1], log_sel[1], 3'b0, log_we[1]},
        {32'h2000_004C, 32'hAAAA0000, 4'hF, 4'h1});
    repeat (2) @(posedge clk);
    #1;
    chk("sw_ack_pulse", ack_cnt, 1);

    // empty select
    clr();
    req(32'h3000_0000, 16'h0000, 1'b0, '0, lat, ak, er, rd);
    chk("nosel_lat", lat, 1);
    chk("nosel_ack", {ak, er}, 2'b10);
    chk("nosel_rdat", rd, 0);
    @(posedge clk);
    #1;
    chk("nosel_cyc", cyc_cnt, 0);

    // error on lane 1
    clr();
    err_en = 1'b1;
    req(32'h3000_0100, 16'hFFFF, 1'b0, '0, lat, ak, er, rd);
    chk("err_lat", lat, 4);
    chk("err_flags", {ak, er}, 2'b01);
    chk("err_rdat", rd, {96'd0, 32'h11111111});
    chk("err_n", log_adr.size(), 2);
    repeat (3) @(posedge clk);
    #1;
    chk("err_pulse", {err_cnt[7:0], ack_cnt[7:0]}, 16'h0100);
    chk("err_stb", stb_cnt, 2);
    err_en = 1'b0;

    // timeout, slave never answers
    clr();
    hang = 1'b1;
    req(32'h5000_0000, 16'hFFFF, 1'b0, '0, lat, ak, er, rd);
    chk("to_lat", lat, 9);
    chk("to_flags", {ak, er}, 2'b01);
    chk("to_stb", stb_cnt, 8);
    hang = 1'b0;
    @(posedge clk);
    #1;
    clr();
    req(32'h4000_0010, 16'h00F0, 1'b0, '0, lat, ak, er, rd);
    chk("after_to_lat", lat, 2);
    chk("after_to_rdat", rd, {64'd0, 32'h22222222, 32'd0});
    chk("after_to_adr", log_adr[0], 32'h4000_0014);

    // upstream abort during GAP
    @(posedge clk);
    #1;
    clr();
    s_bus.adr = 32'h6000_0000;
    s_bus.sel = 16'hFFFF;
    s_bus.we  = 1'b0;
    s_bus.cyc = 1'b1;
    s_bus.stb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_gap", {m_bus.cyc, m_bus.stb}, 2'b10);
    s_bus.cyc = 1'b0;
    s_bus.stb = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cyc", {m_bus.cyc, m_bus.stb}, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_noresp", {ack_cnt[7:0], err_cnt[7:0]}, 16'h0000);

    // reset mid-XFER
    s_bus.adr  = 32'h7000_0000;
    s_bus.sel  = 16'hFFFF;
    s_bus.we   = 1'b1;
    s_bus.wdat = {4{32'hCAFE_F00D}};
    s_bus.cyc  = 1'b1;
    s_bus.stb  = 1'b1;
    @(posedge clk);
    #1;
    chk("rx_stb", {m_bus.cyc, m_bus.stb, m_bus.we}, 3'b111);
    rst       = 1'b1;
    s_bus.cyc = 1'b0;
    s_bus.stb = 1'b0;
    @(posedge clk);
    #1;
    chk("rx_ctl", {m_bus.cyc, m_bus.stb, s_bus.ack, s_bus.err, m_bus.we}, 0);
    chk("rx_data", {m_bus.adr, m_bus.sel, m_bus.wdat}, 0);
    chk("rx_rdat", s_bus.rdat, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single lane read after reset
    clr();
    req(32'h8000_0000, 16'h0F00, 1'b0, '0, lat, ak, er, rd);
    chk("post_lat", lat, 2);
    chk("post_rdat", rd, {32'd0, 32'h33333333, 64'd0});
    chk("post_adr", log_adr[0], 32'h8000_0008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
